// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - MAC datapath sequencer: clear, feed, drain, capture (optional MAC_SEQ_ABORT_EN)
module mac_seq_ctrl #(
  parameter int LEN_W   = 6,
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mul_en,
  output logic             acc_clr,
  output logic             acc_en,
  input  logic [ACC_W-1:0] acc_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
`ifdef MAC_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic [MUL_LAT-1:0] r_pipe;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_in_ready;
  logic               r_acc_clr;
  logic               r_res_valid;
  logic [ACC_W-1:0]   r_res_data;
`ifdef MAC_SEQ_ABORT_EN
  logic               r_aborted;
`endif

  logic               w_beat;
  logic [MUL_LAT-1:0] w_pipe_nxt;

  // An abort in the same cycle wins over an offered beat.
`ifdef MAC_SEQ_ABORT_EN
  assign w_beat = in_valid & r_in_ready & ~abort;
`else
  assign w_beat = in_valid & r_in_ready;
`endif

  // The pipe tracks which multiplier slots carry a real product.
  generate
    if (MUL_LAT == 1) begin : g_pipe1
      assign w_pipe_nxt = w_beat;
    end else begin : g_pipen
      assign w_pipe_nxt = {r_pipe[MUL_LAT-2:0], w_beat};
    end
  endgenerate

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign mul_en    = w_beat;
  assign acc_clr   = r_acc_clr;
  assign acc_en    = r_pipe[MUL_LAT-1];
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
`ifdef MAC_SEQ_ABORT_EN
  assign aborted   = r_aborted;
`endif

  // Job FSM with registered handshake/control outputs and the latency pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pipe      <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
`ifdef MAC_SEQ_ABORT_EN
      r_aborted   <= 1'b0;
`endif
    end else begin
      r_pipe    <= w_pipe_nxt;
      r_acc_clr <= 1'b0;
`ifdef MAC_SEQ_ABORT_EN
      r_aborted <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state     <= S_IDLE;
        r_pipe      <= '0;
        r_cnt       <= '0;
        r_busy      <= 1'b0;
        r_in_ready  <= 1'b0;
        r_acc_clr   <= 1'b1;
        r_res_valid <= 1'b0;
        r_aborted   <= 1'b1;
      end else
`endif
      begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_busy <= 1'b1;
              if (len != '0) begin
                r_state   <= S_CLEAR;
                r_cnt     <= len;
                r_acc_clr <= 1'b1;
              end else begin
                r_state     <= S_HOLD;
                r_res_data  <= '0;
                r_res_valid <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            r_state    <= S_FEED;
            r_in_ready <= 1'b1;
          end
          S_FEED: begin
            if (w_beat) begin
              r_cnt <= r_cnt - LEN_W'(1);
              if (r_cnt == LEN_W'(1)) begin
                r_state    <= S_DRAIN;
                r_in_ready <= 1'b0;
              end
            end
          end
          S_DRAIN: begin
            // Empty pipe means the last product has landed in acc_q.
            if (r_pipe == '0) begin
              r_state     <= S_HOLD;
              r_res_data  <= acc_q;
              r_res_valid <= 1'b1;
            end
          end
          S_HOLD: begin
            if (res_ready) begin
              r_state     <= S_IDLE;
              r_res_valid <= 1'b0;
              r_busy      <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl with a MAC datapath model
module tb_mac_seq_ctrl;

  localparam int LEN_W   = 6;
  localparam int MUL_LAT = 2;
  localparam int ACC_W   = 22;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic             mul_en;
  logic             acc_clr;
  logic             acc_en;
  logic [ACC_W-1:0] acc_q;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [15:0]      prod_in;
`ifdef MAC_SEQ_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  int total = 0;
  int bad   = 0;

  mac_seq_ctrl #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_en    (mul_en),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .acc_q     (acc_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
`ifdef MAC_SEQ_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: products queue behind mul_en, the accumulator pops one per acc_en.
  int               cyc = 0;
  int               mon_mul, mon_acc, mon_clr, mon_bad;
  int               mul_t[$];
  logic [15:0]      prod_q[$];
  logic [ACC_W-1:0] acc;
  assign acc_q = acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_t.delete();
      prod_q.delete();
      acc <= '0;
    end else begin
      cyc++;
      if (acc_clr && acc_en) mon_bad++;
      if (acc_clr) begin
        mon_clr++;
        acc <= '0;
      end else if (acc_en) begin
        mon_acc++;
        if (mul_t.size() == 0) mon_bad++;
        else begin
          if (cyc - mul_t.pop_front() != MUL_LAT) mon_bad++;
          acc <= acc + ACC_W'(prod_q.pop_front());
        end
      end
      if (mul_en) begin
        mon_mul++;
        mul_t.push_back(cyc);
        prod_q.push_back(prod_in);
      end
`ifdef MAC_SEQ_ABORT_EN
      if (aborted) begin
        mul_t.delete();
        prod_q.delete();
      end
`endif
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, in_ready, mul_en, acc_clr, acc_en, res_valid, res_data});
  endfunction

  // One job: start, feed per mode (0 always valid, 1 gap pattern, 2 random), then unload.
  task automatic run_job(input int l, input int mode, input bit ones, input int hold,
                         input bit poke_start, input string tag);
    int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [31:0] exp_sum = 0;
    int          nb = 0;
    bit          to = 1'b1;
    mon_mul = 0; mon_acc = 0; mon_clr = 0; mon_bad = 0;
    start = 1'b1; len = LEN_W'(l); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (c == 0) ? 1'b1 : ((c - 1 < 7) ? pat[c-1][0] : 1'b1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      prod_in = ones ? 16'hFFFF : 16'($urandom);
      #1;
      if (in_valid && in_ready) begin
        exp_sum += 32'(prod_in);
        nb++;
      end
      if (res_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_timeout"}, 64'(to), 64'(0));
    chk({tag, "_res_data"}, 64'(res_data), 64'(exp_sum[ACC_W-1:0]));
    chk({tag, "_beats"}, 64'(nb), 64'(l));
    chk({tag, "_mul_en"}, 64'(mon_mul), 64'(l));
    chk({tag, "_acc_en"}, 64'(mon_acc), 64'(l));
    chk({tag, "_acc_clr"}, 64'(mon_clr), 64'(l != 0));
    chk({tag, "_align"}, 64'(mon_bad), 64'(0));
    for (int i = 0; i < hold; i++) begin
      if (poke_start && i == 0) begin
        start = 1'b1;
        len = LEN_W'(5);
      end
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      chk({tag, "_hold_valid"}, 64'(res_valid), 64'(1));
      chk({tag, "_hold_data"}, 64'(res_data), 64'(exp_sum[ACC_W-1:0]));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    #1;
    chk({tag, "_done_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done_valid"}, 64'(res_valid), 64'(0));
    if (poke_start) begin
      @(posedge clk); #2;
      chk({tag, "_start_ignored"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; res_ready = 1'b0; prod_in = '0;
`ifdef MAC_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", all_outs(), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("idle_busy", 64'(busy), 64'(0));

    run_job(3, 0, 1'b0, 0, 1'b0, "len3");
    run_job(4, 1, 1'b0, 0, 1'b0, "gaps");
    run_job(0, 0, 1'b0, 5, 1'b0, "len0");
    run_job(63, 0, 1'b1, 2, 1'b1, "len63");
    chk("len63_const", 64'(res_data), 64'(22'h3EFFC1));
    for (int j = 0; j < 6; j++) run_job(int'($urandom_range(1, 20)), 2, 1'b0, 1, 1'b0, "rand");

    // Asynchronous reset in the middle of FEED.
    start = 1'b1; len = LEN_W'(10); in_valid = 1'b1; prod_in = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pre_feed", 64'(in_ready), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_feed", all_outs(), 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_recover_idle", 64'(busy), 64'(0));
    run_job(7, 2, 1'b0, 0, 1'b0, "post_rst");

`ifdef MAC_SEQ_ABORT_EN
    begin
      logic [ACC_W-1:0] prev;
      bit seen_ready = 1'b0;
      bit in_drain = 1'b0;
      bit any_valid = 1'b0;
      prev = res_data;
      start = 1'b1; len = LEN_W'(3); in_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 50; c++) begin
        #1;
        if (in_ready) seen_ready = 1'b1;
        else if (seen_ready) begin
          in_drain = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("abort_reach_drain", 64'(in_drain), 64'(1));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      #1;
      chk("abort_pulse", 64'(aborted), 64'(1));
      chk("abort_clr", 64'(acc_clr), 64'(1));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_data", 64'(res_data), 64'(prev));
      @(posedge clk); #2;
      chk("abort_pulse_end", 64'({aborted, acc_clr}), 64'(0));
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #2;
        if (res_valid) any_valid = 1'b1;
      end
      chk("abort_no_result", 64'(any_valid), 64'(0));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      #1;
      chk("abort_idle_noop", 64'({aborted, acc_clr, busy}), 64'(0));
      run_job(5, 0, 1'b0, 0, 1'b0, "post_abort");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
